// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared constants, FSM state type and a small saturating helper for the LED
// sequence monitor.
//   CODE_W      width of the code from the upstream pseudo-random counter
//   NUM_LEDS    number of one-hot LED drives (2**CODE_W)
//   EQ_RUN_W    width of the equal-sample run counter (saturates at 7)
//   seq_state_t period-measurement FSM states
// -----------------------------------------------------------------------------
package led_seq_pkg;

  localparam int CODE_W   = 3;
  localparam int NUM_LEDS = 8;
  localparam int EQ_RUN_W = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,  // waiting for the first sample to become the reference
    S_MEASURE = 2'd1,  // counting samples until the reference code repeats
    S_LOCKED  = 2'd2   // period known; every later repeat is checked against it
  } seq_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [EQ_RUN_W-1:0] sat_inc_run(input logic [EQ_RUN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/led_seq_monitor_onehot_dec_3x8.sv
// -----------------------------------------------------------------------------
// onehot_dec_3x8
// Combinational 3-to-8 one-hot decoder.
//   i_code    in  CODE_W    binary code
//   o_onehot  out NUM_LEDS  1 << i_code
// -----------------------------------------------------------------------------
module onehot_dec_3x8
  import led_seq_pkg::*;
(
  input  logic [CODE_W-1:0]   i_code,
  output logic [NUM_LEDS-1:0] o_onehot
);

  always_comb begin
    o_onehot         = '0;
    o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/led_seq_monitor.sv
// -----------------------------------------------------------------------------
// led_seq_monitor
// Consumer of the 3-bit pseudo-random LED counter. Decodes each sampled code to
// a registered one-hot LED drive, keeps a sticky mask of codes seen, measures
// the sequence period against the first sampled code and flags a stuck or
// non-repeating source.
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high; clears all state
//   en            in   sample enable; code_in is consumed only when 1
//   code_in       in   [2:0] code from the upstream counter
//   led_onehot    out  [7:0] one-hot decode of the last sampled code
//   seen          out  [7:0] sticky mask of sampled codes
//   all_seen      out  sticky, seen == 8'hFF
//   period        out  [PERIOD_W-1:0] samples between first two reference hits
//   period_valid  out  period holds a measured value
//   period_err    out  sticky, a later repeat interval differed from period
//   ovf           out  sticky, reference did not repeat within 2^PERIOD_W-1
//   stuck         out  sticky, STUCK_MAX consecutive equal-sample comparisons
// -----------------------------------------------------------------------------
module led_seq_monitor
  import led_seq_pkg::*;
#(
  parameter int PERIOD_W  = 4,
  parameter int STUCK_MAX = 3
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [CODE_W-1:0]   code_in,
  output logic [NUM_LEDS-1:0] led_onehot,
  output logic [NUM_LEDS-1:0] seen,
  output logic                all_seen,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                period_err,
  output logic                ovf,
  output logic                stuck
);

  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);
  localparam logic [EQ_RUN_W-1:0] STUCK_THR = EQ_RUN_W'(STUCK_MAX);

  // Registered state
  seq_state_t          r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic [CODE_W-1:0]   r_ref_code;
  logic [CODE_W-1:0]   r_prev_code;
  logic                r_prev_valid;
  logic [EQ_RUN_W-1:0] r_eq_run;
  logic [NUM_LEDS-1:0] r_led;
  logic [NUM_LEDS-1:0] r_seen;
  logic                r_all_seen;
  logic [PERIOD_W-1:0] r_period;
  logic                r_period_valid;
  logic                r_period_err;
  logic                r_ovf;
  logic                r_stuck;

  // Next-state values
  seq_state_t          w_state_nxt;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic [CODE_W-1:0]   w_ref_code_nxt;
  logic [CODE_W-1:0]   w_prev_code_nxt;
  logic                w_prev_valid_nxt;
  logic [EQ_RUN_W-1:0] w_eq_run_nxt;
  logic [NUM_LEDS-1:0] w_led_nxt;
  logic [NUM_LEDS-1:0] w_seen_nxt;
  logic                w_all_seen_nxt;
  logic [PERIOD_W-1:0] w_period_nxt;
  logic                w_period_valid_nxt;
  logic                w_period_err_nxt;
  logic                w_ovf_nxt;
  logic                w_stuck_nxt;

  logic [NUM_LEDS-1:0] w_dec;
  logic                w_is_ref;

  // One decoder feeds both the LED drive and the seen-mask update.
  onehot_dec_3x8 u_dec (
    .i_code   (code_in),
    .o_onehot (w_dec)
  );

  assign w_is_ref = (code_in == r_ref_code);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the branches below leaves one unassigned and no latch is inferred.
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_ref_code_nxt     = r_ref_code;
    w_prev_code_nxt    = r_prev_code;
    w_prev_valid_nxt   = r_prev_valid;
    w_eq_run_nxt       = r_eq_run;
    w_led_nxt          = r_led;
    w_seen_nxt         = r_seen;
    w_all_seen_nxt     = r_all_seen;
    w_period_nxt       = r_period;
    w_period_valid_nxt = r_period_valid;
    w_period_err_nxt   = r_period_err;
    w_ovf_nxt          = r_ovf;
    w_stuck_nxt        = r_stuck;

    if (en) begin
      // Decode and coverage; all_seen looks at the mask being written so it
      // rises on the same edge that completes it.
      w_led_nxt      = w_dec;
      w_seen_nxt     = r_seen | w_dec;
      w_all_seen_nxt = r_all_seen | (w_seen_nxt == '1);

      // Stuck detect: the first sample after reset has nothing to compare to.
      w_prev_code_nxt  = code_in;
      w_prev_valid_nxt = 1'b1;
      if (r_prev_valid && (code_in == r_prev_code)) begin
        w_eq_run_nxt = sat_inc_run(r_eq_run);
      end else begin
        w_eq_run_nxt = '0;
      end
      w_stuck_nxt = r_stuck | (w_eq_run_nxt >= STUCK_THR);

      // Period measurement
      case (r_state)
        S_IDLE: begin
          w_ref_code_nxt = code_in;
          w_cnt_nxt      = CNT_ONE;
          w_state_nxt    = S_MEASURE;
        end

        S_MEASURE: begin
          if (w_is_ref) begin
            w_period_nxt       = r_cnt;
            w_period_valid_nxt = 1'b1;
            w_cnt_nxt          = CNT_ONE;
            w_state_nxt        = S_LOCKED;
          end else if (r_cnt == CNT_MAX) begin
            // Reference never came back; the next sample re-arms.
            w_ovf_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end

        S_LOCKED: begin
          if (w_is_ref) begin
            if (r_cnt != r_period) begin
              w_period_err_nxt = 1'b1;
            end
            w_cnt_nxt = CNT_ONE;
          end else if (r_cnt == CNT_MAX) begin
            // Interval already longer than any legal period.
            w_period_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_ref_code     <= '0;
      r_prev_code    <= '0;
      r_prev_valid   <= 1'b0;
      r_eq_run       <= '0;
      r_led          <= '0;
      r_seen         <= '0;
      r_all_seen     <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_period_err   <= 1'b0;
      r_ovf          <= 1'b0;
      r_stuck        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_ref_code     <= w_ref_code_nxt;
      r_prev_code    <= w_prev_code_nxt;
      r_prev_valid   <= w_prev_valid_nxt;
      r_eq_run       <= w_eq_run_nxt;
      r_led          <= w_led_nxt;
      r_seen         <= w_seen_nxt;
      r_all_seen     <= w_all_seen_nxt;
      r_period       <= w_period_nxt;
      r_period_valid <= w_period_valid_nxt;
      r_period_err   <= w_period_err_nxt;
      r_ovf          <= w_ovf_nxt;
      r_stuck        <= w_stuck_nxt;
    end
  end

  assign led_onehot   = r_led;
  assign seen         = r_seen;
  assign all_seen     = r_all_seen;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign period_err   = r_period_err;
  assign ovf          = r_ovf;
  assign stuck        = r_stuck;

endmodule

// File: tb/tb_led_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_led_seq_monitor
// Self-checking bench for led_seq_monitor: a table of the full sequence,
// hand-written corner sequences, and randomized stimulus compared against a
// model that re-derives every output from the list of samples since reset.
// -----------------------------------------------------------------------------
module tb_led_seq_monitor;

  localparam int PW   = 4;
  localparam int SM   = 3;
  localparam int CMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [2:0]    code_in;
  logic [7:0]    led_onehot;
  logic [7:0]    seen;
  logic          all_seen;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          period_err;
  logic          ovf;
  logic          stuck;

  led_seq_monitor #(.PERIOD_W(PW), .STUCK_MAX(SM)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .code_in      (code_in),
    .led_onehot   (led_onehot),
    .seen         (seen),
    .all_seen     (all_seen),
    .period       (period),
    .period_valid (period_valid),
    .period_err   (period_err),
    .ovf          (ovf),
    .stuck        (stuck)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Every code sampled since the last reset, oldest first.
  logic [2:0] hist[$];

  typedef struct packed {
    logic [7:0]    led;
    logic [7:0]    seen;
    logic          all_seen;
    logic [PW-1:0] period;
    logic          valid;
    logic          err;
    logic          ovf;
    logic          stuck;
  } exp_t;

  typedef struct {
    logic [2:0]    code;
    logic [7:0]    led;
    logic [7:0]    seen;
    logic          all_seen;
    logic [PW-1:0] period;
    logic          valid;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs derived directly from the sample history.
  function automatic exp_t model();
    exp_t       e;
    int         n;
    int         s;
    int         hit;
    int         last;
    int         run;
    logic [2:0] r;
    e    = '0;
    n    = hist.size();
    run  = 0;
    for (int i = 0; i < n; i++) begin
      e.seen |= 8'(1) << hist[i];
      e.led   = 8'(1) << hist[i];
      run     = (i > 0 && hist[i] == hist[i-1]) ? run + 1 : 1;
      if (run >= SM + 1) e.stuck = 1'b1;
    end
    e.all_seen = (e.seen == 8'hFF);
    // Find the first reference whose code recurs within CMAX samples.
    s    = 0;
    last = -1;
    while (s < n && last < 0) begin
      hit = -1;
      for (int j = s + 1; j < n && j <= s + CMAX; j++)
        if (hit < 0 && hist[j] == hist[s]) hit = j;
      if (hit >= 0) begin
        e.period = PW'(hit - s);
        e.valid  = 1'b1;
        last     = hit;
      end else if (n > s + CMAX) begin
        e.ovf = 1'b1;
        s     = s + CMAX + 1;
      end else begin
        s = n;
      end
    end
    if (last >= 0) begin
      r = hist[s];
      for (int k = last + 1; k < n; k++) begin
        if (hist[k] == r) begin
          if (k - last != int'(e.period)) e.err = 1'b1;
          last = k;
        end
      end
      if (n - 1 - last >= CMAX) e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic check_model(input string tag);
    exp_t e;
    e = model();
    check({tag, ".led"},      32'(led_onehot),   32'(e.led));
    check({tag, ".seen"},     32'(seen),         32'(e.seen));
    check({tag, ".all_seen"}, 32'(all_seen),     32'(e.all_seen));
    check({tag, ".period"},   32'(period),       32'(e.period));
    check({tag, ".valid"},    32'(period_valid), 32'(e.valid));
    check({tag, ".err"},      32'(period_err),   32'(e.err));
    check({tag, ".ovf"},      32'(ovf),          32'(e.ovf));
    check({tag, ".stuck"},    32'(stuck),        32'(e.stuck));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs read there too.
  task automatic sample(input logic e, input logic [2:0] c);
    en      = e;
    code_in = c;
    @(posedge clk);
    #1;
    if (e) hist.push_back(c);
  endtask

  task automatic do_reset();
    en    = 1'b0;
    reset = 1'b1;
    hist.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_t       tbl[9];
    logic [2:0] seq[8];
    logic [2:0] pat[8];
    int         plen;
    int         pos;
    logic [2:0] c;

    seq[0] = 3'd3; seq[1] = 3'd6; seq[2] = 3'd1; seq[3] = 3'd7;
    seq[4] = 3'd0; seq[5] = 3'd5; seq[6] = 3'd2; seq[7] = 3'd4;

    tbl[0] = '{3'd3, 8'h08, 8'h08, 1'b0, 4'd0, 1'b0};
    tbl[1] = '{3'd6, 8'h40, 8'h48, 1'b0, 4'd0, 1'b0};
    tbl[2] = '{3'd1, 8'h02, 8'h4A, 1'b0, 4'd0, 1'b0};
    tbl[3] = '{3'd7, 8'h80, 8'hCA, 1'b0, 4'd0, 1'b0};
    tbl[4] = '{3'd0, 8'h01, 8'hCB, 1'b0, 4'd0, 1'b0};
    tbl[5] = '{3'd5, 8'h20, 8'hEB, 1'b0, 4'd0, 1'b0};
    tbl[6] = '{3'd2, 8'h04, 8'hEF, 1'b0, 4'd0, 1'b0};
    tbl[7] = '{3'd4, 8'h10, 8'hFF, 1'b1, 4'd0, 1'b0};
    tbl[8] = '{3'd3, 8'h08, 8'hFF, 1'b1, 4'd8, 1'b1};

    // Reset state, checked before any clock edge.
    reset   = 1'b0;
    en      = 1'b0;
    code_in = 3'd0;
    #1 reset = 1'b1;
    #1;
    check_model("por");
    @(posedge clk);
    #1 reset = 1'b0;

    // Full sequence from the table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sample(1'b1, tbl[i].code);
      check($sformatf("tbl%0d.led", i),      32'(led_onehot),   32'(tbl[i].led));
      check($sformatf("tbl%0d.seen", i),     32'(seen),         32'(tbl[i].seen));
      check($sformatf("tbl%0d.all_seen", i), 32'(all_seen),     32'(tbl[i].all_seen));
      check($sformatf("tbl%0d.period", i),   32'(period),       32'(tbl[i].period));
      check($sformatf("tbl%0d.valid", i),    32'(period_valid), 32'(tbl[i].valid));
    end
    for (int k = 9; k <= 32; k++) begin
      sample(1'b1, seq[k % 8]);
      check_model("full");
    end
    check("full.period_err_4cyc", 32'(period_err), 32'd0);
    check("full.period_final",    32'(period),     32'd8);

    // Stuck source.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      sample(1'b1, 3'd5);
      if (i == 2) begin
        check("stuck.period2", 32'(period),       32'd1);
        check("stuck.valid2",  32'(period_valid), 32'd1);
      end
      if (i == 3) check("stuck.not_yet", 32'(stuck), 32'd0);
    end
    check("stuck.set4", 32'(stuck), 32'd1);

    // Enable gating with random codes on idle cycles.
    do_reset();
    pos = 0;
    while (pos < 17) begin
      sample(1'b0, 3'($urandom_range(0, 7)));
      check_model("gate.idle");
      sample(1'b1, seq[pos % 8]);
      pos++;
      check_model("gate.smp");
      if (pos == 4) check("gate.seen4", 32'(seen), 32'h0CA);
    end
    check("gate.period", 32'(period),       32'd8);
    check("gate.valid",  32'(period_valid), 32'd1);

    // Overflow: reference 2, then 15 samples alternating 0/1.
    do_reset();
    sample(1'b1, 3'd2);
    for (int i = 0; i < 15; i++) begin
      sample(1'b1, (i % 2 == 0) ? 3'd0 : 3'd1);
      if (i == 13) check("ovf.not_yet", 32'(ovf), 32'd0);
    end
    check("ovf.set",   32'(ovf),          32'd1);
    check("ovf.valid", 32'(period_valid), 32'd0);
    check_model("ovf");
    sample(1'b1, 3'd6);
    sample(1'b1, 3'd6);
    check("ovf.rearm_period", 32'(period),       32'd1);
    check("ovf.rearm_valid",  32'(period_valid), 32'd1);

    // Period mismatch: lock at 8, then the reference returns after 6.
    do_reset();
    for (int k = 0; k < 9; k++) sample(1'b1, seq[k % 8]);
    check("mis.locked_err", 32'(period_err), 32'd0);
    sample(1'b1, 3'd6);
    sample(1'b1, 3'd1);
    sample(1'b1, 3'd7);
    sample(1'b1, 3'd0);
    sample(1'b1, 3'd5);
    sample(1'b1, 3'd3);
    check("mis.err",    32'(period_err), 32'd1);
    check("mis.period", 32'(period),     32'd8);
    check_model("mis");

    // Asynchronous reset in the middle of a measurement.
    do_reset();
    sample(1'b1, 3'd0);
    sample(1'b1, 3'd1);
    sample(1'b1, 3'd2);
    sample(1'b1, 3'd3);
    check("arst.seen_before", 32'(seen), 32'h00F);
    #2;
    reset = 1'b1;
    hist.delete();
    #1;
    check_model("arst.async");
    @(posedge clk);
    #1 reset = 1'b0;
    sample(1'b1, 3'd5);
    sample(1'b1, 3'd5);
    check("arst.rearm_period", 32'(period),       32'd1);
    check("arst.rearm_valid",  32'(period_valid), 32'd1);

    // Randomized: a repeating pattern with noise, runs and occasional resets.
    do_reset();
    plen = 8;
    pos  = 0;
    for (int i = 0; i < 8; i++) pat[i] = 3'($urandom_range(0, 7));
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        check_model("rnd.rst");
      end
      if ($urandom_range(0, 99) == 0) begin
        plen = $urandom_range(1, 8);
        for (int i = 0; i < 8; i++) pat[i] = 3'($urandom_range(0, 7));
      end
      case ($urandom_range(0, 9))
        0:       c = 3'($urandom_range(0, 7));
        1:       c = (hist.size() > 0) ? hist[hist.size() - 1] : 3'd0;
        default: begin
          c   = pat[pos % plen];
          pos = pos + 1;
        end
      endcase
      sample(($urandom_range(0, 3) != 0), c);
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
